// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   localparam int DMEM_AW    = 8;
   localparam int DMEM_DW    = 8;
   localparam int DMEM_DEPTH = 32'd1 << DMEM_AW;

   localparam int PORT_CORE = 0;
   localparam int PORT_LDR  = 1;

   typedef enum logic [0:0] {
      ST_ARB = 1'b0,
      ST_CLR = 1'b1
   } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int AW = DMEM_AW,
   parameter int DW = DMEM_DW
) ();

   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wr_en;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output mem_addr, mem_wdata, mem_wr_en, mem_rd_en,
      input  mem_rdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  mem_addr, mem_wdata, mem_wr_en, mem_rd_en,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; pointer reset favours port 0.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_q = 1 means port 1 was granted most recently
   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
         if (gnt != 2'b00) begin
            last_d = gnt[1];
         end else begin
            last_d = last_q;
         end
      end else begin
         gnt    = 2'b00;
         last_d = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer for the single-port data memory.
// Optional bulk-clear engine is built when DMEM_ARB_CLEAR_EN is defined.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int            AW      = DMEM_AW,
   parameter int            DW      = DMEM_DW,
   parameter logic [DW-1:0] CLR_VAL = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   dmem_arbiter_if.slave bus
);

   logic [1:0]    req_s;
   logic [1:0]    gnt_s;
   logic          arb_en_s;
   logic          sel_s;

   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          mem_wr_en_q, mem_wr_en_d;
   logic          mem_rd_en_q, mem_rd_en_d;
   logic          iss_port_q,  iss_port_d;
   logic          rvalid0_q,   rvalid0_d;
   logic          rvalid1_q,   rvalid1_d;
   logic [DW-1:0] rdata0_q,    rdata0_d;
   logic [DW-1:0] rdata1_q,    rdata1_d;
   logic          clr_busy_q,  clr_busy_d;
   logic          clr_done_q,  clr_done_d;

`ifdef DMEM_ARB_CLEAR_EN
   state_e        state_q, state_d;
   // One extra bit: the carry out of the increment marks the last address
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   cnt_inc_s;

   assign cnt_inc_s = cnt_q + {{AW{1'b0}}, 1'b1};
   assign arb_en_s  = (state_q == ST_ARB) && !clr_start;
`else
   logic          unused_clr_start_s;

   assign unused_clr_start_s = clr_start;
   assign arb_en_s           = 1'b1;
`endif

   assign req_s = {bus.req1, bus.req0};
   assign sel_s = gnt_s[PORT_LDR];

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en_s),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_en_d = 1'b0;
      mem_rd_en_d = 1'b0;
      iss_port_d  = iss_port_q;
      clr_busy_d  = 1'b0;
      clr_done_d  = 1'b0;
      if (gnt_s != 2'b00) begin
         iss_port_d  = sel_s;
         mem_addr_d  = sel_s ? bus.addr1  : bus.addr0;
         mem_wdata_d = sel_s ? bus.wdata1 : bus.wdata0;
         mem_wr_en_d = sel_s ? bus.we1    : bus.we0;
         mem_rd_en_d = sel_s ? ~bus.we1   : ~bus.we0;
      end else begin
         iss_port_d  = iss_port_q;
      end
`ifdef DMEM_ARB_CLEAR_EN
      state_d = state_q;
      cnt_d   = cnt_q;
      // Grants are already suppressed in the cases below, so clear writes own the issue stage
      case (state_q)
         ST_ARB: begin
            if (clr_start) begin
               state_d     = ST_CLR;
               cnt_d       = {(AW+1){1'b0}};
               mem_addr_d  = {AW{1'b0}};
               mem_wdata_d = CLR_VAL;
               mem_wr_en_d = 1'b1;
               mem_rd_en_d = 1'b0;
               clr_busy_d  = 1'b1;
            end else begin
               state_d     = ST_ARB;
            end
         end
         ST_CLR: begin
            if (cnt_inc_s[AW]) begin
               state_d     = ST_ARB;
               cnt_d       = {(AW+1){1'b0}};
               clr_done_d  = 1'b1;
            end else begin
               cnt_d       = cnt_inc_s;
               mem_addr_d  = cnt_inc_s[AW-1:0];
               mem_wdata_d = CLR_VAL;
               mem_wr_en_d = 1'b1;
               clr_busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_ARB;
            cnt_d   = {(AW+1){1'b0}};
         end
      endcase
`endif
   end

   always_comb begin
      rvalid0_d = mem_rd_en_q && !iss_port_q;
      rvalid1_d = mem_rd_en_q &&  iss_port_q;
      if (rvalid0_d) begin
         rdata0_d = bus.mem_rdata;
      end else begin
         rdata0_d = rdata0_q;
      end
      if (rvalid1_d) begin
         rdata1_d = bus.mem_rdata;
      end else begin
         rdata1_d = rdata1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q  <= {AW{1'b0}};
         mem_wdata_q <= {DW{1'b0}};
         mem_wr_en_q <= 1'b0;
         mem_rd_en_q <= 1'b0;
         iss_port_q  <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= {DW{1'b0}};
         rdata1_q    <= {DW{1'b0}};
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
`ifdef DMEM_ARB_CLEAR_EN
         state_q     <= ST_ARB;
         cnt_q       <= {(AW+1){1'b0}};
`endif
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_en_q <= mem_wr_en_d;
         mem_rd_en_q <= mem_rd_en_d;
         iss_port_q  <= iss_port_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         clr_busy_q  <= clr_busy_d;
         clr_done_q  <= clr_done_d;
`ifdef DMEM_ARB_CLEAR_EN
         state_q     <= state_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.gnt0      = gnt_s[PORT_CORE];
   assign bus.gnt1      = gnt_s[PORT_LDR];
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wr_en = mem_wr_en_q;
   assign bus.mem_rd_en = mem_rd_en_q;
   assign clr_busy      = clr_busy_q;
   assign clr_done      = clr_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x8 behavioural memory.
module tb_dmem_arbiter;

   logic clk;
   logic reset;
   logic clr_start;
   logic clr_busy;
   logic clr_done;
   int   checks;
   int   errors;
   logic [7:0] mem [0:255];

   dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

   dmem_arbiter #(.AW(8), .DW(8), .CLR_VAL(8'h00)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = mem[bus.mem_addr];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive0(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
   endtask

   task automatic drive1(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
   endtask

   task automatic idle();
      drive0(1'b0, 1'b0, 8'h00, 8'h00);
      drive1(1'b0, 1'b0, 8'h00, 8'h00);
      clr_start = 1'b0;
   endtask

   task automatic test_reset();
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_wr_en, bus.mem_rd_en, clr_busy, clr_done} !== 8'h00) begin
         errors++; $display("FAIL reset_ctl: got %b expected 00000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_wr_en, bus.mem_rd_en, clr_busy, clr_done});
      end
      checks++;
      if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== 32'h0000_0000) begin
         errors++; $display("FAIL reset_data: got %h expected 00000000", {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata});
      end
      step();
   endtask

   task automatic test_write_read();
      drive0(1'b1, 1'b1, 8'h10, 8'hA5);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", {bus.gnt1, bus.gnt0}); end
      step();
      drive0(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b expected 01", {bus.gnt1, bus.gnt0}); end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_wr_en, bus.mem_rd_en} !== {8'h10, 8'hA5, 1'b1, 1'b0}) begin
         errors++; $display("FAIL wr_issue: got %h/%h/%b%b expected 10/a5/10", bus.mem_addr, bus.mem_wdata, bus.mem_wr_en, bus.mem_rd_en);
      end
      step();
      drive0(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      checks++;
      if ({bus.mem_addr, bus.mem_wr_en, bus.mem_rd_en, bus.rvalid0} !== {8'h10, 1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rd_issue: got %h/%b%b rv=%b expected 10/01 rv=0", bus.mem_addr, bus.mem_wr_en, bus.mem_rd_en, bus.rvalid0);
      end
      step();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {1'b1, 1'b0, 8'hA5}) begin
         errors++; $display("FAIL rd_return: got rv=%b%b data=%h expected rv=10 data=a5", bus.rvalid0, bus.rvalid1, bus.rdata0);
      end
      step();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b0, 8'hA5}) begin
         errors++; $display("FAIL rd_hold: got rv=%b data=%h expected rv=0 data=a5", bus.rvalid0, bus.rdata0);
      end
      step();
   endtask

   task automatic test_alternate();
      int n0;
      int n1;
      n0 = 0; n1 = 0;
      reset = 1'b1; idle(); step(); reset = 1'b0;
      drive0(1'b1, 1'b1, 8'h20, 8'h01); drive1(1'b1, 1'b1, 8'h30, 8'h02);
      #1; n0 += int'(bus.gnt0); n1 += int'(bus.gnt1);
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL alt_c1: got %b expected 01", {bus.gnt1, bus.gnt0}); end
      step();
      drive0(1'b1, 1'b1, 8'h21, 8'h03);
      #1; n0 += int'(bus.gnt0); n1 += int'(bus.gnt1);
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.mem_addr} !== {2'b10, 8'h20}) begin errors++; $display("FAIL alt_c2: got %b/%h expected 10/20", {bus.gnt1, bus.gnt0}, bus.mem_addr); end
      step();
      drive1(1'b1, 1'b1, 8'h31, 8'h04);
      #1; n0 += int'(bus.gnt0); n1 += int'(bus.gnt1);
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.mem_addr} !== {2'b01, 8'h30}) begin errors++; $display("FAIL alt_c3: got %b/%h expected 01/30", {bus.gnt1, bus.gnt0}, bus.mem_addr); end
      step();
      drive0(1'b1, 1'b1, 8'h22, 8'h05);
      #1; n0 += int'(bus.gnt0); n1 += int'(bus.gnt1);
      checks++;
      if ({bus.gnt1, bus.gnt0, bus.mem_addr} !== {2'b10, 8'h21}) begin errors++; $display("FAIL alt_c4: got %b/%h expected 10/21", {bus.gnt1, bus.gnt0}, bus.mem_addr); end
      step();
      idle();
      #1;
      checks++;
      if (bus.mem_addr !== 8'h31) begin errors++; $display("FAIL alt_last_issue: got %h expected 31", bus.mem_addr); end
      checks++;
      if (n0 != 2 || n1 != 2) begin errors++; $display("FAIL alt_counts: got %0d/%0d expected 2/2", n0, n1); end
      step();
   endtask

   task automatic test_back_to_back();
      drive1(1'b1, 1'b1, 8'h40, 8'h77);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL b2b_wr_gnt: got %b expected 10", {bus.gnt1, bus.gnt0}); end
      step();
      drive1(1'b1, 1'b0, 8'h20, 8'h00); drive0(1'b1, 1'b0, 8'h40, 8'h00);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL b2b_rr: got %b expected 01", {bus.gnt1, bus.gnt0}); end
      step();
      drive0(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL b2b_gnt1: got %b expected 10", {bus.gnt1, bus.gnt0}); end
      step();
      idle();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {2'b10, 8'h77}) begin errors++; $display("FAIL b2b_raw: got rv=%b%b data=%h expected rv=10 data=77", bus.rvalid0, bus.rvalid1, bus.rdata0); end
      step();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rvalid1, bus.rdata1} !== {2'b01, 8'h01}) begin errors++; $display("FAIL b2b_rd1: got rv=%b%b data=%h expected rv=01 data=01", bus.rvalid0, bus.rvalid1, bus.rdata1); end
      step();
   endtask

`ifdef DMEM_ARB_CLEAR_EN
   task automatic test_clear();
      logic [7:0] exp_a;
      drive0(1'b1, 1'b1, 8'hFF, 8'h3C); step(); idle(); step();
      drive1(1'b1, 1'b0, 8'hFF, 8'h00); clr_start = 1'b1;
      #1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b00) begin errors++; $display("FAIL clr_start_gnt: got %b expected 00", {bus.gnt1, bus.gnt0}); end
      step();
      for (int k = 1; k <= 256; k++) begin
         clr_start = (k == 51) ? 1'b1 : 1'b0;
         exp_a = 8'(k - 1);
         #1;
         checks++;
         if ({clr_busy, clr_done, bus.gnt1, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata} !== {4'b1001, exp_a, 8'h00}) begin
            errors++; $display("FAIL clr_cycle%0d: got busy=%b done=%b gnt1=%b we=%b addr=%h wd=%h expected 1/0/0/1/%h/00", k, clr_busy, clr_done, bus.gnt1, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, exp_a);
         end
         step();
      end
      clr_start = 1'b0;
      #1;
      checks++;
      if ({clr_done, clr_busy, bus.gnt1, bus.mem_wr_en} !== 4'b1010) begin errors++; $display("FAIL clr_done: got done=%b busy=%b gnt1=%b we=%b expected 1/0/1/0", clr_done, clr_busy, bus.gnt1, bus.mem_wr_en); end
      step();
      idle();
      #1;
      checks++;
      if ({clr_done, bus.mem_rd_en, bus.mem_addr} !== {2'b01, 8'hFF}) begin errors++; $display("FAIL clr_post: got done=%b rd=%b addr=%h expected 0/1/ff", clr_done, bus.mem_rd_en, bus.mem_addr); end
      step();
      #1;
      checks++;
      if ({bus.rvalid1, bus.rdata1} !== {1'b1, 8'h00}) begin errors++; $display("FAIL clr_readback: got rv=%b data=%h expected rv=1 data=00", bus.rvalid1, bus.rdata1); end
      step();
   endtask

   task automatic test_clear_reset();
      drive0(1'b1, 1'b1, 8'h63, 8'h3C); step();
      drive0(1'b1, 1'b1, 8'h64, 8'h3C); step();
      drive0(1'b1, 1'b1, 8'hC8, 8'h3C); step();
      idle(); step();
      clr_start = 1'b1; step(); clr_start = 1'b0;
      for (int k = 1; k < 100; k++) step();
      #1;
      checks++;
      if ({clr_busy, bus.mem_addr} !== {1'b1, 8'h63}) begin errors++; $display("FAIL clrrst_pos: got busy=%b addr=%h expected 1/63", clr_busy, bus.mem_addr); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_wr_en, bus.mem_rd_en, clr_busy, clr_done} !== 8'h00) begin
         errors++; $display("FAIL clrrst_ctl: got %b expected 00000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_wr_en, bus.mem_rd_en, clr_busy, clr_done});
      end
      checks++;
      if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== 32'h0000_0000) begin
         errors++; $display("FAIL clrrst_data: got %h expected 00000000", {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata});
      end
      for (int k = 0; k < 5; k++) begin
         step();
         #1;
         checks++;
         if ({clr_busy, clr_done} !== 2'b00) begin errors++; $display("FAIL clrrst_nodone%0d: got busy=%b done=%b expected 0/0", k, clr_busy, clr_done); end
      end
      drive0(1'b1, 1'b0, 8'h64, 8'h00); step();
      drive0(1'b1, 1'b0, 8'hC8, 8'h00); step();
      drive0(1'b1, 1'b0, 8'h63, 8'h00);
      #1;
      checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL clrrst_a100: got rv=%b data=%h expected rv=1 data=3c", bus.rvalid0, bus.rdata0); end
      step();
      idle();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL clrrst_a200: got rv=%b data=%h expected rv=1 data=3c", bus.rvalid0, bus.rdata0); end
      step();
      #1;
      checks++;
      if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'h00}) begin errors++; $display("FAIL clrrst_a99: got rv=%b data=%h expected rv=1 data=00", bus.rvalid0, bus.rdata0); end
      step();
   endtask
`else
   task automatic test_no_clear();
      drive0(1'b1, 1'b0, 8'h10, 8'h00); clr_start = 1'b1;
      #1;
      checks++;
      if ({bus.gnt0, clr_busy} !== 2'b10) begin errors++; $display("FAIL noclr_gnt: got gnt0=%b busy=%b expected 1/0", bus.gnt0, clr_busy); end
      step();
      idle();
      #1;
      checks++;
      if ({clr_busy, clr_done, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0010) begin errors++; $display("FAIL noclr_issue: got busy=%b done=%b rd=%b wr=%b expected 0/0/1/0", clr_busy, clr_done, bus.mem_rd_en, bus.mem_wr_en); end
      step();
      #1;
      checks++;
      if ({clr_busy, clr_done, bus.rvalid0, bus.rdata0} !== {3'b001, 8'hA5}) begin errors++; $display("FAIL noclr_ret: got busy=%b done=%b rv=%b data=%h expected 0/0/1/a5", clr_busy, clr_done, bus.rvalid0, bus.rdata0); end
      step();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      @(negedge clk);
      step();
      test_reset();
      test_write_read();
`ifndef DMEM_ARB_CLEAR_EN
      test_no_clear();
`endif
      test_alternate();
      test_back_to_back();
`ifdef DMEM_ARB_CLEAR_EN
      test_clear();
      test_clear_reset();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
